// File: rtl/sum_block_accumulator_pkg.sv
// Shared types and constants for the block accumulator: default widths,
// a constant-foldable clog2 and the block-total / phase types.
package sum_block_accumulator_pkg;

  localparam int DEF_IN_W      = 16;
  localparam int DEF_ACC_W     = 20;
  localparam int DEF_BLOCK_LEN = 4;
  localparam int DEF_DEPTH     = 2;
  localparam int BLOCKS_W      = 16;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  typedef logic [DEF_ACC_W-1:0] block_total_t;

  // ACCUM while more results are needed; LAST when the next accept closes a block
  typedef enum logic {
    PH_ACCUM = 1'b0,
    PH_LAST  = 1'b1
  } phase_t;

endpackage

// File: rtl/sum_block_accumulator_if.sv
// Input-result and block-total handshakes plus status, grouped for the
// accumulator (slave) and whatever drives/consumes it (master).
interface sum_block_accumulator_if
  import sum_block_accumulator_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = clog2(DEF_BLOCK_LEN)
) ();

  logic                io_in_valid;
  logic [IN_W-1:0]     io_in_bits;
  logic                io_in_ready;
  logic                io_clear;
  logic                io_out_valid;
  logic [ACC_W-1:0]    io_out_bits;
  logic                io_out_ready;
  logic [CNT_W-1:0]    io_count;
  logic [BLOCKS_W-1:0] io_blocks;

  modport slave (
    input  io_in_valid, io_in_bits, io_clear, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_count, io_blocks
  );

  modport master (
    output io_in_valid, io_in_bits, io_clear, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_count, io_blocks
  );

endinterface

// File: rtl/sum_block_accumulator_sum_fifo.sv
// Small synchronous FIFO for completed block totals; head reads as zero when empty.
module sum_fifo
  import sum_block_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_ACC_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   occ_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (occ_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/sum_block_accumulator.sv
// Sums BLOCK_LEN accepted adder results into one block total and queues the
// totals in a small FIFO drained by a valid/ready sink.
module sum_block_accumulator
  import sum_block_accumulator_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int BLOCK_LEN = DEF_BLOCK_LEN,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic clk,
  input  logic reset,
  sum_block_accumulator_if.slave io
);

  localparam int CNT_W = clog2(BLOCK_LEN);

  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [BLOCKS_W-1:0] blocks_reg, blocks_next;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                in_ready;
  logic                accept;
  logic                push;
  logic                pop;
  phase_t              phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      count_reg  <= '0;
      blocks_reg <= '0;
    end else begin
      acc_reg    <= acc_next;
      count_reg  <= count_next;
      blocks_reg <= blocks_next;
    end
  end

  // Ready looks only at registered state: a pop this cycle cannot make room
  // for the block being closed in the same cycle.
  always_comb begin
    acc_next    = acc_reg;
    count_next  = count_reg;
    blocks_next = blocks_reg;
    push        = 1'b0;
    phase       = (count_reg == CNT_W'(BLOCK_LEN - 1)) ? PH_LAST : PH_ACCUM;
    sum         = acc_reg + ACC_W'(io.io_in_bits);
    in_ready    = !reset && !(phase == PH_LAST && fifo_full);
    accept      = io.io_in_valid && in_ready;
    if (io.io_clear) begin
      acc_next   = '0;
      count_next = '0;
    end else if (accept) begin
      if (phase == PH_LAST) begin
        push        = 1'b1;
        acc_next    = '0;
        count_next  = '0;
        blocks_next = blocks_reg + 1'b1;
      end else begin
        acc_next   = sum;
        count_next = count_reg + 1'b1;
      end
    end
  end

  assign pop = !fifo_empty && io.io_out_ready;

  sum_fifo #(
    .WIDTH(ACC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .srst   (reset),
    .push   (push),
    .wr_data(sum),
    .pop    (pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign io.io_in_ready  = in_ready;
  assign io.io_out_valid = !fifo_empty;
  assign io.io_out_bits  = fifo_head;
  assign io.io_count     = count_reg;
  assign io.io_blocks    = blocks_reg;

endmodule
